// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and constants for the data memory responder.
package data_mem_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_LANES = 4;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: single-port word array, synchronous per-lane write, combinational read.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] lanes,
  input  logic [ADDR_W-1:0]     idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);
  logic [WORD_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    for (int i = 0; i < BYTE_LANES; i++)
      if (we && lanes[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[idx];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data RAM responder with ready/stall handshake.
// Optional byte-lane write strobes via DATA_MEM_BYTE_STROBE_EN.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_ram_ena,
  input  logic                  data_ram_wea,
  input  logic [WORD_W-1:0]     addr,
  input  logic [WORD_W-1:0]     wdata,
`ifdef DATA_MEM_BYTE_STROBE_EN
  input  logic [BYTE_LANES-1:0] byte_en,
`endif
  output logic                  ready,
  output logic                  rvalid,
  output logic [WORD_W-1:0]     rdata,
  output logic                  err
);
  localparam bit DIRECT = (WAIT_CYCLES == 0);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic wea_q;
  logic [ADDR_W+1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic accept, go, op_wea, mis, we;
  logic [ADDR_W+1:0] op_addr;
  logic [WORD_W-1:0] op_wdata, mem_q;
  logic [BYTE_LANES-1:0] lanes;
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[WORD_W-1:ADDR_W+2];
  assign accept = data_ram_ena && ready;
  // with no wait states the access happens on the acceptance edge itself
  assign go = DIRECT ? accept : (state == WAIT && cnt == '0);
  assign op_wea = DIRECT ? data_ram_wea : wea_q;
  assign op_addr = DIRECT ? addr[ADDR_W+1:0] : addr_q;
  assign op_wdata = DIRECT ? wdata : wdata_q;
`ifdef DATA_MEM_BYTE_STROBE_EN
  logic [BYTE_LANES-1:0] be_q, op_be;
  assign op_be = DIRECT ? byte_en : be_q;
  // partial strobes are legal when no enabled lane sits below the byte offset
  assign mis = (op_be == '1) ? |op_addr[1:0]
             : |(op_be & ((BYTE_LANES'(1) << op_addr[1:0]) - BYTE_LANES'(1)));
  assign lanes = op_be;
`else
  assign mis = |op_addr[1:0];
  assign lanes = '1;
`endif
  assign we = go && op_wea && !mis && !rst;
  data_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk(clk), .we(we), .lanes(lanes), .idx(op_addr[ADDR_W+1:2]),
    .wdata(op_wdata), .rdata(mem_q)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      rvalid <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
      cnt <= '0;
    end else begin
      rvalid <= 1'b0;
      err <= 1'b0;
      if (accept) begin
        wea_q <= data_ram_wea;
        addr_q <= addr[ADDR_W+1:0];
        wdata_q <= wdata;
`ifdef DATA_MEM_BYTE_STROBE_EN
        be_q <= byte_en;
`endif
      end
      if (go) begin
        state <= DONE;
        ready <= 1'b1;
        rvalid <= 1'b1;
        err <= mis;
        if (!op_wea) rdata <= mis ? '0 : mem_q;
      end else if (accept) begin
        state <= WAIT;
        ready <= 1'b0;
        cnt <= CNT_W'(WAIT_CYCLES - 1);
      end else if (state == WAIT) cnt <= cnt - 1'b1;
      else state <= IDLE;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks on a 2-wait-state and a 0-wait-state responder.
module tb_data_mem_responder;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic a_ena = 0, a_wea = 0, b_ena = 0, b_wea = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
`ifdef DATA_MEM_BYTE_STROBE_EN
  logic [3:0] a_be = 4'hf, b_be = 4'hf;
`endif
  int checks = 0, errors = 0;

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .data_ram_ena(a_ena), .data_ram_wea(a_wea),
    .addr(a_addr), .wdata(a_wdata),
`ifdef DATA_MEM_BYTE_STROBE_EN
    .byte_en(a_be),
`endif
    .ready(a_ready), .rvalid(a_rvalid), .rdata(a_rdata), .err(a_err));

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .data_ram_ena(b_ena), .data_ram_wea(b_wea),
    .addr(b_addr), .wdata(b_wdata),
`ifdef DATA_MEM_BYTE_STROBE_EN
    .byte_en(b_be),
`endif
    .ready(b_ready), .rvalid(b_rvalid), .rdata(b_rdata), .err(b_err));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // one request on dut_a; lat counts edges from acceptance to the edge that samples rvalid
  task automatic op_a(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd, output logic e,
                      output int lat, output int low);
    int k = 0;
    a_ena = 1; a_wea = we; a_addr = a; a_wdata = d;
`ifdef DATA_MEM_BYTE_STROBE_EN
    a_be = be;
`else
    if (be != 4'hf) $display("strobe ignored");
`endif
    while (!a_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    a_ena = 0;
    lat = 1; low = 0;
    while (!a_rvalid && lat < 20) begin
      if (!a_ready) low++;
      @(negedge clk);
      lat++;
    end
    rd = a_rdata; e = a_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic e;
    int lat, low, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_ready", {31'b0, a_ready}, 1);
    check("rst_rvalid", {31'b0, a_rvalid}, 0);
    check("rst_err", {31'b0, a_err}, 0);
    check("rst_rdata", a_rdata, 0);
    n = 0;
    repeat (10) begin @(negedge clk); n += int'(a_rvalid) + int'(b_rvalid); end
    check("idle_pulses", n, 0);

    op_a(1, 32'h10, 32'hDEADBEEF, 4'hf, rd, e, lat, low);
    check("wr_lat", lat, 3);
    check("wr_stall", low, 2);
    check("wr_err", {31'b0, e}, 0);
    @(negedge clk);
    check("rvalid_one_cycle", {31'b0, a_rvalid}, 0);
    op_a(0, 32'h10, 0, 4'hf, rd, e, lat, low);
    check("rd_lat", lat, 3);
    check("rd_stall", low, 2);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err", {31'b0, e}, 0);

    op_a(0, 32'h13, 0, 4'hf, rd, e, lat, low);
    check("mis_rd_err", {31'b0, e}, 1);
    check("mis_rd_data", rd, 0);
    op_a(1, 32'h12, 32'hFFFFFFFF, 4'hf, rd, e, lat, low);
    check("mis_wr_err", {31'b0, e}, 1);
    check("mis_wr_lat", lat, 3);
    op_a(0, 32'h10, 0, 4'hf, rd, e, lat, low);
    check("mis_wr_noupd", rd, 32'hDEADBEEF);

    op_a(1, 32'h1000, 32'hA5A5A5A5, 4'hf, rd, e, lat, low);
    op_a(0, 32'h0, 0, 4'hf, rd, e, lat, low);
    check("alias", rd, 32'hA5A5A5A5);

    op_a(1, 32'h20, 32'h0BADF00D, 4'hf, rd, e, lat, low);
    a_ena = 1; a_wea = 1; a_addr = 32'h20; a_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    a_ena = 0; rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("abort_ready", {31'b0, a_ready}, 1);
    n = 0;
    repeat (6) begin n += int'(a_rvalid); @(negedge clk); end
    check("abort_pulses", n, 0);
    op_a(0, 32'h20, 0, 4'hf, rd, e, lat, low);
    check("abort_nowrite", rd, 32'h0BADF00D);

`ifdef DATA_MEM_BYTE_STROBE_EN
    op_a(1, 32'h8, 32'h0, 4'hf, rd, e, lat, low);
    op_a(1, 32'h8, 32'h0000AB00, 4'b0010, rd, e, lat, low);
    check("strobe_err", {31'b0, e}, 0);
    op_a(0, 32'h8, 0, 4'hf, rd, e, lat, low);
    check("strobe_data", rd, 32'h0000AB00);
`endif

    check("b_ready", {31'b0, b_ready}, 1);
    b_ena = 1; b_wea = 1; b_addr = 32'h0; b_wdata = 32'h11111111;
    @(posedge clk); @(negedge clk);
    check("b2b_wr0_rvalid", {31'b0, b_rvalid}, 1);
    b_addr = 32'h4; b_wdata = 32'h22222222;
    @(posedge clk); @(negedge clk);
    check("b2b_wr1_rvalid", {31'b0, b_rvalid}, 1);
    b_wea = 0; b_addr = 32'h0;
    @(posedge clk); @(negedge clk);
    check("b2b_rd0_rvalid", {31'b0, b_rvalid}, 1);
    check("b2b_rd0_data", b_rdata, 32'h11111111);
    b_addr = 32'h4;
    @(posedge clk); @(negedge clk);
    check("b2b_rd1_rvalid", {31'b0, b_rvalid}, 1);
    check("b2b_rd1_data", b_rdata, 32'h22222222);
    check("b2b_rd1_err", {31'b0, b_err}, 0);
    b_ena = 0;
    @(posedge clk); @(negedge clk);
    check("b2b_end_rvalid", {31'b0, b_rvalid}, 0);
    check("b2b_hold_data", b_rdata, 32'h22222222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
